// File: rtl/pong_pkg.sv
// pong_pkg: shared game state, paddle direction and paddle FSM encodings.
package pong_pkg;
  localparam int VER_PIXELS = 768;
  typedef enum logic [1:0] {IDLE, PLAY, SCORE, OVER} game_state_t;
  typedef enum logic [1:0] {NONE, UP, DOWN} pad_dir_t;
  typedef enum logic [1:0] {HOLD, RAMP, CRUISE} pad_fsm_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/pad_motion_ctrl.sv
// pad_motion_ctrl: paddle motion with velocity ramping, manual/auto request and limit clamping.
module pad_motion_ctrl
  import pong_pkg::*;
#(
  parameter int Y_WIDTH     = 10,
  parameter int PAD_HEIGHT  = 145,
  parameter int Y_TOP_LIMIT = 6,
  parameter int Y_BOT_LIMIT = VER_PIXELS - 6,
  parameter int Y_HOME      = 312,
  parameter int V_MAX       = 8,
  parameter int ACCEL_TICKS = 4,
  parameter int DEADBAND    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               timing_tick,
  input  logic [1:0]         state,
  input  logic               mode,
  input  logic               up_in,
  input  logic               down_in,
  input  logic [Y_WIDTH-1:0] target_y,
  output logic [Y_WIDTH-1:0] y_pad,
  output logic [3:0]         speed,
  output logic [1:0]         dir,
  output logic               at_limit
);
  localparam int CW = $clog2(ACCEL_TICKS + 1);
  localparam logic [Y_WIDTH:0] TOP = (Y_WIDTH+1)'(Y_TOP_LIMIT);
  localparam logic [Y_WIDTH:0] BOT = (Y_WIDTH+1)'(Y_BOT_LIMIT - PAD_HEIGHT + 1);
  localparam logic [Y_WIDTH:0] HOME = (Y_WIDTH+1)'(Y_HOME);
  localparam logic signed [Y_WIDTH+1:0] HALF = (Y_WIDTH+2)'(PAD_HEIGHT / 2);
  localparam logic signed [Y_WIDTH+1:0] DB = (Y_WIDTH+2)'(DEADBAND);
  logic up_s, down_s, play, clamp, at_top, at_bot;
  pad_fsm_t fsm_q, fsm_n;
  pad_dir_t dir_q, dir_n, req;
  logic [3:0] spd_q, spd_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [Y_WIDTH:0] y_ext, spd_ext, y_sum, y_dif, y_n;
  logic signed [Y_WIDTH+1:0] centre, tgt;
  sync_2ff u_sync_up (.clk(clk), .rst(rst), .d(up_in), .q(up_s));
  sync_2ff u_sync_down (.clk(clk), .rst(rst), .d(down_in), .q(down_s));
  assign play = game_state_t'(state) == PLAY;
  assign centre = $signed({2'b00, y_pad}) + HALF;
  assign tgt = $signed({2'b00, target_y});
  assign at_top = {1'b0, y_pad} == TOP;
  assign at_bot = {1'b0, y_pad} == BOT;
  assign speed = spd_q;
  assign dir = dir_q;
  always_comb begin
    req = NONE;
    if (mode) req = tgt > centre + DB ? DOWN : tgt < centre - DB ? UP : NONE;
    else req = up_s && !down_s ? UP : down_s && !up_s ? DOWN : NONE;
  end
  // A request pressing into the limit we sit on never leaves HOLD.
  always_comb begin
    fsm_n = fsm_q;
    dir_n = dir_q;
    spd_n = spd_q;
    cnt_n = cnt_q;
    if (req == NONE) begin
      fsm_n = HOLD;
      dir_n = NONE;
      spd_n = '0;
      cnt_n = '0;
    end else if (fsm_q == HOLD ? !(req == UP && at_top || req == DOWN && at_bot) : req != dir_q) begin
      fsm_n = V_MAX == 1 ? CRUISE : RAMP;
      dir_n = req;
      spd_n = 4'd1;
      cnt_n = '0;
    end else if (fsm_q == RAMP) begin
      cnt_n = cnt_q + CW'(1);
      if (cnt_n == CW'(ACCEL_TICKS)) begin
        cnt_n = '0;
        spd_n = spd_q + 4'd1;
        fsm_n = spd_n == 4'(V_MAX) ? CRUISE : RAMP;
      end
    end
  end
  // Reaching a limit counts as clamping, so the paddle always rests there in HOLD.
  always_comb begin
    y_ext = {1'b0, y_pad};
    spd_ext = (Y_WIDTH+1)'(spd_n);
    y_sum = y_ext + spd_ext;
    y_dif = y_ext - spd_ext;
    clamp = dir_n == DOWN ? y_sum >= BOT : dir_n == UP ? y_ext <= TOP + spd_ext : 1'b0;
    y_n = !play ? HOME : !timing_tick ? y_ext :
          dir_n == DOWN ? (clamp ? BOT : y_sum) : dir_n == UP ? (clamp ? TOP : y_dif) : y_ext;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fsm_q <= HOLD;
      dir_q <= NONE;
      spd_q <= '0;
      cnt_q <= '0;
    end else if (!play) begin
      fsm_q <= HOLD;
      dir_q <= NONE;
      spd_q <= '0;
      cnt_q <= '0;
    end else if (timing_tick) begin
      fsm_q <= clamp ? HOLD : fsm_n;
      dir_q <= clamp ? NONE : dir_n;
      spd_q <= clamp ? '0 : spd_n;
      cnt_q <= clamp ? '0 : cnt_n;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      y_pad <= HOME[Y_WIDTH-1:0];
      at_limit <= 1'b0;
    end else begin
      y_pad <= y_n[Y_WIDTH-1:0];
      at_limit <= y_n == TOP || y_n == BOT;
    end
endmodule

// File: tb/tb_pad_motion_ctrl.sv
// tb_pad_motion_ctrl: directed checks of reset, ramping, clamping, auto mode and state override.
module tb_pad_motion_ctrl;
  import pong_pkg::*;
  logic clk = 0, rst = 1, timing_tick = 0, mode = 0, up_in = 0, down_in = 0;
  logic [1:0] state = PLAY;
  logic [9:0] target_y = 0;
  logic [9:0] y_pad;
  logic [3:0] speed;
  logic [1:0] dir;
  logic at_limit;
  int total = 0, bad = 0;
  pad_motion_ctrl dut (
    .clk(clk), .rst(rst), .timing_tick(timing_tick), .state(state), .mode(mode),
    .up_in(up_in), .down_in(down_in), .target_y(target_y),
    .y_pad(y_pad), .speed(speed), .dir(dir), .at_limit(at_limit)
  );
  always #5 clk = ~clk;
  task automatic tick;
    repeat (3) @(negedge clk);
    timing_tick = 1;
    @(negedge clk);
    timing_tick = 0;
  endtask
  task automatic test_reset;
    #1 rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    total++; if (y_pad !== 10'd312) begin bad++; $display("FAIL reset_y got=%0d exp=312", y_pad); end
    total++; if (speed !== 4'd0) begin bad++; $display("FAIL reset_speed got=%0d exp=0", speed); end
    total++; if (dir !== NONE) begin bad++; $display("FAIL reset_dir got=%0d exp=0", dir); end
    total++; if (at_limit !== 1'b0) begin bad++; $display("FAIL reset_at_limit got=%0b exp=0", at_limit); end
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (y_pad !== 10'd312 || speed !== 4'd0) begin bad++; $display("FAIL idle_tick%0d y=%0d speed=%0d exp 312/0", i, y_pad, speed); end
    end
  endtask
  task automatic test_auto;
    mode = 1;
    target_y = 10'd386;
    tick;
    total++; if (y_pad !== 10'd312 || speed !== 4'd0 || dir !== NONE) begin bad++; $display("FAIL auto_dead y=%0d s=%0d d=%0d exp 312/0/0", y_pad, speed, dir); end
    target_y = 10'd400;
    tick;
    total++; if (y_pad !== 10'd313 || speed !== 4'd1 || dir !== DOWN) begin bad++; $display("FAIL auto_down y=%0d s=%0d d=%0d exp 313/1/2", y_pad, speed, dir); end
    target_y = 10'd300;
    tick;
    total++; if (y_pad !== 10'd312 || speed !== 4'd1 || dir !== UP) begin bad++; $display("FAIL auto_up y=%0d s=%0d d=%0d exp 312/1/1", y_pad, speed, dir); end
    target_y = 10'd384;
    tick;
    total++; if (y_pad !== 10'd312 || speed !== 4'd0 || dir !== NONE) begin bad++; $display("FAIL auto_stop y=%0d s=%0d d=%0d exp 312/0/0", y_pad, speed, dir); end
    mode = 0;
  endtask
  task automatic test_state;
    down_in = 1;
    tick;
    tick;
    total++; if (y_pad !== 10'd314) begin bad++; $display("FAIL pre_idle_y got=%0d exp=314", y_pad); end
    state = IDLE;
    @(negedge clk);
    total++; if (y_pad !== 10'd312 || speed !== 4'd0 || dir !== NONE) begin bad++; $display("FAIL leave_play y=%0d s=%0d d=%0d exp 312/0/0", y_pad, speed, dir); end
    tick;
    total++; if (y_pad !== 10'd312) begin bad++; $display("FAIL idle_hold_y got=%0d exp=312", y_pad); end
    down_in = 0;
    state = PLAY;
  endtask
  task automatic test_ramp;
    int exp_s[13] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 4};
    int exp_y[13] = '{313, 314, 315, 316, 318, 320, 322, 324, 327, 330, 333, 336, 340};
    down_in = 1;
    for (int i = 0; i < 13; i++) begin
      tick;
      total++; if (speed !== 4'(exp_s[i]) || y_pad !== 10'(exp_y[i]) || dir !== DOWN) begin bad++; $display("FAIL ramp%0d y=%0d s=%0d d=%0d exp %0d/%0d/2", i, y_pad, speed, dir, exp_y[i], exp_s[i]); end
    end
    repeat (16) tick;
    total++; if (speed !== 4'd8 || y_pad !== 10'd432) begin bad++; $display("FAIL reach_vmax y=%0d s=%0d exp 432/8", y_pad, speed); end
    tick;
    total++; if (speed !== 4'd8 || y_pad !== 10'd440) begin bad++; $display("FAIL cruise y=%0d s=%0d exp 440/8", y_pad, speed); end
    for (int i = 0; i < 40 && !at_limit; i++) tick;
    total++; if (y_pad !== 10'd618 || speed !== 4'd0 || dir !== NONE || at_limit !== 1'b1) begin bad++; $display("FAIL bottom_clamp y=%0d s=%0d d=%0d lim=%0b exp 618/0/0/1", y_pad, speed, dir, at_limit); end
    tick;
    total++; if (y_pad !== 10'd618 || speed !== 4'd0 || at_limit !== 1'b1) begin bad++; $display("FAIL press_into_limit y=%0d s=%0d lim=%0b exp 618/0/1", y_pad, speed, at_limit); end
    down_in = 0;
    up_in = 1;
    tick;
    total++; if (y_pad !== 10'd617 || speed !== 4'd1 || dir !== UP || at_limit !== 1'b0) begin bad++; $display("FAIL leave_limit y=%0d s=%0d d=%0d lim=%0b exp 617/1/1/0", y_pad, speed, dir, at_limit); end
  endtask
  task automatic test_combo;
    down_in = 1;
    tick;
    total++; if (y_pad !== 10'd617 || speed !== 4'd0 || dir !== NONE) begin bad++; $display("FAIL both_pressed y=%0d s=%0d d=%0d exp 617/0/0", y_pad, speed, dir); end
    down_in = 0;
    tick;
    total++; if (y_pad !== 10'd616 || speed !== 4'd1 || dir !== UP) begin bad++; $display("FAIL up_again y=%0d s=%0d d=%0d exp 616/1/1", y_pad, speed, dir); end
    up_in = 0;
    down_in = 1;
    tick;
    total++; if (y_pad !== 10'd617 || speed !== 4'd1 || dir !== DOWN) begin bad++; $display("FAIL reversal y=%0d s=%0d d=%0d exp 617/1/2", y_pad, speed, dir); end
    down_in = 0;
    tick;
    total++; if (y_pad !== 10'd617 || speed !== 4'd0 || dir !== NONE) begin bad++; $display("FAIL release y=%0d s=%0d d=%0d exp 617/0/0", y_pad, speed, dir); end
  endtask
  task automatic test_back_to_back;
    int exp_y[5] = '{616, 615, 614, 613, 611};
    int exp_s[5] = '{1, 1, 1, 1, 2};
    up_in = 1;
    repeat (3) @(negedge clk);
    timing_tick = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (y_pad !== 10'(exp_y[i]) || speed !== 4'(exp_s[i])) begin bad++; $display("FAIL b2b%0d y=%0d s=%0d exp %0d/%0d", i, y_pad, speed, exp_y[i], exp_s[i]); end
    end
    timing_tick = 0;
  endtask
  task automatic test_async_reset;
    @(negedge clk);
    timing_tick = 1;
    #2 rst = 0;
    #1;
    total++; if (y_pad !== 10'd312 || speed !== 4'd0 || dir !== NONE || at_limit !== 1'b0) begin bad++; $display("FAIL async_reset y=%0d s=%0d d=%0d lim=%0b exp 312/0/0/0", y_pad, speed, dir, at_limit); end
    timing_tick = 0;
    up_in = 0;
    @(negedge clk);
    rst = 1;
  endtask
  initial begin
    test_reset;
    test_auto;
    test_state;
    test_ramp;
    test_combo;
    test_back_to_back;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pad_motion_ctrl.md
# pad_motion_ctrl

Parametrised paddle motion controller for the pong game logic: generalises the fixed-speed player paddle into a block with configurable geometry and limits, velocity ramping, and a selectable manual (button) or automatic (ball-tracking) mode. It sits between the input/ball logic and the pad renderer. Per `timing_tick` it updates a registered paddle top coordinate `y_pad` in screen pixels, and holds the paddle at home position outside the play state.

## Interface
Parameters:
- `Y_WIDTH`, 10: width of every vertical coordinate.
- `PAD_HEIGHT`, 145: paddle height in pixels.
- `Y_TOP_LIMIT`, 6: smallest allowed `y_pad`.
- `Y_BOT_LIMIT`, 762: largest allowed paddle bottom row (`y_pad + PAD_HEIGHT - 1`).
- `Y_HOME`, 312: `y_pad` at reset and outside play.
- `V_MAX`, 8: maximum speed in pixels per tick, 1..15.
- `ACCEL_TICKS`, 4: ticks per +1 speed step, ≥1.
- `DEADBAND`, 4: auto-mode tolerance in pixels.

Ports:
- `clk`, input, 1: system clock; the only clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `timing_tick`, input, 1: one-cycle motion strobe.
- `state`, input, 2: game state (`game_state_t`).
- `mode`, input, 1: 0 = manual, 1 = auto; sampled per tick.
- `up_in`, input, 1: asynchronous up button.
- `down_in`, input, 1: asynchronous down button.
- `target_y`, input, `Y_WIDTH`: ball centre row, used in auto mode.
- `y_pad`, output, `Y_WIDTH`: registered paddle top row.
- `speed`, output, 4: current speed magnitude.
- `dir`, output, 2: current direction (`pad_dir_t`: NONE/UP/DOWN).
- `at_limit`, output, 1: high while `y_pad` equals either limit.

## Operation
- `up_in` and `down_in` each pass through a 2-flop synchronizer.
- Requested direction, manual mode: up only gives UP, down only gives DOWN, both or neither gives NONE.
- Requested direction, auto mode: centre = `y_pad + PAD_HEIGHT/2`.
  - `target_y > centre + DEADBAND` gives DOWN.
  - `target_y < centre - DEADBAND` gives UP.
  - Otherwise NONE.
  - Compare in `Y_WIDTH+2` bits, signed; no wrap.
- FSM `pad_fsm_t` has states HOLD, RAMP, CRUISE. It evaluates only on cycles with `timing_tick=1` while `state == PLAY`.
  - HOLD, request ≠ NONE: go to RAMP, `dir` = request, speed = 1, tick counter cleared.
  - RAMP, same request: counter increments. When it reaches `ACCEL_TICKS`, speed +1 and counter clears. When speed reaches `V_MAX`, go to CRUISE.
  - RAMP or CRUISE, request NONE: go to HOLD, speed 0, `dir` NONE.
  - RAMP or CRUISE, opposite request: go to RAMP in the new direction, speed 1, counter cleared. There is no coasting through zero.
- Position update uses the speed produced by the same tick.
  - Next value is `y_pad ± speed`, computed in `Y_WIDTH+1` bits.
  - Clamp range is `Y_TOP_LIMIT` to `Y_BOT_LIMIT - PAD_HEIGHT + 1`.
  - If clamping occurs: go to HOLD, speed 0, `dir` NONE.
  - A request pressing into a limit does not re-enter RAMP while already at that limit. A request away from the limit does.
- `state != PLAY` is synchronous and overrides everything: `y_pad` = `Y_HOME`, FSM HOLD, speed 0, counter 0.
- Mode switch mid-motion: the new mode's request applies at the next tick under the same rules, e.g. an opposite request reverses.

## Timing
- Reset values, asynchronous: `y_pad` = `Y_HOME`, `speed` = 0, `dir` = NONE, `at_limit` = 0, FSM HOLD, synchronizers 0.
- Button latency: a button must be stable ≥2 `clk` edges before a tick for that tick to see it.
- `y_pad`, `speed` and `dir` update on the edge where `timing_tick=1`. They are constant between ticks.
- `at_limit` is registered and valid in the same cycle as the `y_pad` it describes.
- Consecutive `timing_tick` cycles are legal; each is a full step.
- Leaving PLAY: `y_pad` = `Y_HOME` on the next edge, tick or not.

## Structure
- `pong_pkg` holds:
  - `game_state_t` (2-bit; PLAY among its values), `pad_dir_t`, `pad_fsm_t`;
  - `VER_PIXELS` (768), from which the `Y_BOT_LIMIT` default is derived.
- Sub-module `sync_2ff` (1-bit, async active-low reset), instantiated twice.
- FSM/speed logic and the position/clamp datapath are separate processes in `pad_motion_ctrl`.

## Test plan
- Reset with `state`=PLAY, no input: `y_pad`=312, `speed`=0, `dir`=NONE, `at_limit`=0 indefinitely.
- Manual down held, ticks every 10 clk, defaults:
  - speed sequence 1,1,1,1,2,2,2,2,3… reaching 8 (CRUISE);
  - `y_pad` = 313, 314, 315, 316, 318, …
- Hold down to the bottom: `y_pad` clamps at 618 (762-145+1), speed drops to 0, `at_limit`=1. Continued down leaves it at 618; an up press then moves it to 617.
- Up and down pressed together, or pressing down while moving up: `dir` NONE with speed 0, or a reversal with speed 1 respectively, on the very next tick.
- Auto mode, `y_pad`=312 (centre 384):
  - `target_y`=386: no motion;
  - `target_y`=400: DOWN ramp;
  - `target_y`=300: UP.
- Mid-motion change of `state` to a non-PLAY value: `y_pad`=312 on the next edge with no tick. Asserting `rst` low mid-tick resets immediately, asynchronously.
